// File: rtl/common.sv
// Shared types and defaults for the CPU clocking domain.
package common;

    // Run state of one divider channel.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clk_div_state_t;

    // Default number of cycles from reset release to ready.
    localparam int CLK_DIV_LOCK_DEFAULT = 16;

    // Default divider geometry.
    localparam int CLK_DIV_CHANNELS_DEFAULT  = 2;
    localparam int CLK_DIV_DIV_W_DEFAULT     = 8;
    localparam int CLK_DIV_DIV_RESET_DEFAULT = 2;

endpackage : common

// File: rtl/clk_div_gen_channel.sv
// One divider channel: run state, period counter, active and pending divisor.
// Divisor changes and start/stop take effect only at period boundaries.
module clk_div_channel
    import common::*;
#(
    parameter int DIV_W     = CLK_DIV_DIV_W_DEFAULT,
    parameter int DIV_RESET = CLK_DIV_DIV_RESET_DEFAULT
) (
    input  logic             sys_clk_i,
    input  logic             reset_i,
    input  logic             ready_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             ce_o,
    output logic             clk_o
);

    // A programmed divisor of 0 behaves as 1.
    function automatic logic [DIV_W-1:0] map_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    localparam logic [DIV_W-1:0] DIV_RESET_V = map_div(DIV_W'(DIV_RESET));

    clk_div_state_t   act_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pend_r;
    logic             pend_v_r;

    logic             running;
    logic             boundary;
    logic [DIV_W:0]   half_d;
    logic             apply_en;
    logic [DIV_W-1:0] apply_val;

    assign running  = (act_r == RUN);
    assign boundary = running && (cnt_r == (div_r - DIV_W'(1)));

    // ceil(D/2) in one extra bit so the largest divisor does not wrap.
    assign half_d = ({1'b0, div_r} + (DIV_W + 1)'(1)) >> 1;

    // Outputs are decoded from registers only.
    assign ce_o  = running && (cnt_r == '0);
    assign clk_o = running && ({1'b0, cnt_r} < half_d);

    // Select whether and which divisor becomes active at the next edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        apply_en  = 1'b0;
        apply_val = pend_r;
        if (running) begin
            if (boundary) begin
                // A load landing on the boundary itself bypasses the pending register.
                apply_en  = div_load_i || pend_v_r;
                apply_val = div_load_i ? div_i : pend_r;
            end
        end else begin
            apply_en  = pend_v_r;
            apply_val = pend_r;
        end
    end

    // Divisor registers: pending capture and boundary-aligned activation.
    always_ff @(posedge sys_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            div_r    <= DIV_RESET_V;
            pend_r   <= '0;
            pend_v_r <= 1'b0;
        end else begin
            if (apply_en) begin
                div_r <= map_div(apply_val);
            end
            if (div_load_i && !boundary) begin
                // Last load wins until the value is applied.
                pend_r   <= div_i;
                pend_v_r <= 1'b1;
            end else if (apply_en) begin
                pend_v_r <= 1'b0;
            end
        end
    end

    // Run state and period counter; a stop request waits for the period to end.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            act_r <= IDLE;
            cnt_r <= '0;
        end else begin
            unique case (act_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (run_i && ready_i) begin
                        act_r <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        cnt_r <= '0;
                        if (!run_i) begin
                            act_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1);
                    end
                end
                default: begin
                    act_r <= IDLE;
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule : clk_div_channel

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator with a post-reset lock timer.
// Holds the lock timer and fans ports out to one channel per divider.
module clk_div_gen
    import common::*;
#(
    parameter int CHANNELS    = CLK_DIV_CHANNELS_DEFAULT,
    parameter int DIV_W       = CLK_DIV_DIV_W_DEFAULT,
    parameter int LOCK_CYCLES = CLK_DIV_LOCK_DEFAULT,
    parameter int DIV_RESET   = CLK_DIV_DIV_RESET_DEFAULT
) (
    input  logic                            sys_clk_i,
    input  logic                            reset_i,
    input  logic [CHANNELS-1:0][DIV_W-1:0]  div_i,
    input  logic [CHANNELS-1:0]             div_load_i,
    input  logic [CHANNELS-1:0]             run_i,
    output logic [CHANNELS-1:0]             ce_o,
    output logic [CHANNELS-1:0]             clk_o,
    output logic                            ready_o
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    generate
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("clk_div_gen: LOCK_CYCLES must be at least 1");
        end
    endgenerate

    logic [LOCK_W-1:0] lock_cnt_r;
    logic              ready_r;

    // Lock timer: ready rises on the LOCK_CYCLES-th edge after reset release and then holds.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            lock_cnt_r <= '0;
            ready_r    <= 1'b0;
        end else if (!ready_r) begin
            lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
            if (lock_cnt_r == LOCK_W'(LOCK_CYCLES - 1)) begin
                ready_r <= 1'b1;
            end
        end
    end

    assign ready_o = ready_r;

    // One independent divider per channel.
    generate
        for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
            clk_div_channel #(
                .DIV_W     (DIV_W),
                .DIV_RESET (DIV_RESET)
            ) u_chan (
                .sys_clk_i  (sys_clk_i),
                .reset_i    (reset_i),
                .ready_i    (ready_r),
                .run_i      (run_i[n]),
                .div_i      (div_i[n]),
                .div_load_i (div_load_i[n]),
                .ce_o       (ce_o[n]),
                .clk_o      (clk_o[n])
            );
        end
    endgenerate

endmodule : clk_div_gen

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus a randomized
// run against a period-level behavioural model.
module tb_clk_div_gen;

    localparam int CH     = 2;
    localparam int DW     = 8;
    localparam int LOCK   = 16;
    localparam int DRESET = 2;

    logic               sys_clk = 1'b0;
    logic               reset;
    logic [CH-1:0][DW-1:0] div;
    logic [CH-1:0]      div_load;
    logic [CH-1:0]      run;
    logic [CH-1:0]      ce;
    logic [CH-1:0]      clk_div;
    logic               ready;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: per channel a running flag, position in the period,
    // the period length in use and an optional queued length.
    bit m_act [CH];
    int m_pos [CH];
    int m_d   [CH];
    int m_pend[CH];
    bit m_pv  [CH];
    int m_lock;
    bit m_ready;

    clk_div_gen #(
        .CHANNELS    (CH),
        .DIV_W       (DW),
        .LOCK_CYCLES (LOCK),
        .DIV_RESET   (DRESET)
    ) dut (
        .sys_clk_i  (sys_clk),
        .reset_i    (reset),
        .div_i      (div),
        .div_load_i (div_load),
        .run_i      (run),
        .ce_o       (ce),
        .clk_o      (clk_div),
        .ready_o    (ready)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_lock  = 0;
            m_ready = 0;
            for (int c = 0; c < CH; c++) begin
                m_act[c] = 0;
                m_pos[c] = 0;
                m_d[c]   = eff(DRESET);
                m_pv[c]  = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (m_act[c]) begin
                    if (m_pos[c] == m_d[c] - 1) begin
                        if (div_load[c]) begin
                            m_d[c]  = eff(int'(div[c]));
                            m_pv[c] = 0;
                        end else if (m_pv[c]) begin
                            m_d[c]  = eff(m_pend[c]);
                            m_pv[c] = 0;
                        end
                        m_pos[c] = 0;
                        if (!run[c]) m_act[c] = 0;
                    end else begin
                        m_pos[c]++;
                        if (div_load[c]) begin
                            m_pend[c] = int'(div[c]);
                            m_pv[c]   = 1;
                        end
                    end
                end else begin
                    if (m_pv[c]) begin
                        m_d[c]  = eff(m_pend[c]);
                        m_pv[c] = 0;
                    end
                    if (div_load[c]) begin
                        m_pend[c] = int'(div[c]);
                        m_pv[c]   = 1;
                    end
                    if (run[c] && m_ready) begin
                        m_act[c] = 1;
                        m_pos[c] = 0;
                    end
                end
            end
            if (!m_ready) begin
                m_lock++;
                if (m_lock == LOCK) m_ready = 1;
            end
        end
    endtask

    // Expected {ready, ce[1:0], clk[1:0]} from the model.
    function automatic logic [2*CH:0] exp_vec();
        logic [2*CH:0] v;
        v = '0;
        v[2*CH] = m_ready;
        for (int c = 0; c < CH; c++) begin
            v[CH + c] = m_act[c] && (m_pos[c] == 0);
            v[c]      = m_act[c] && (m_pos[c] < (m_d[c] + 1) / 2);
        end
        return v;
    endfunction

    // Advance one cycle; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge sys_clk);
        model_update();
        #1;
    endtask

    // Steps until ce[ch] is seen; n is the number of steps, or -1 on timeout.
    task automatic wait_ce(input int ch, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (ce[ch]) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic load_div(input int ch, input int v);
        div[ch]      = DW'(v);
        div_load[ch] = 1'b1;
        step();
        div_load[ch] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = '1;
        step();
        step();
        checks++;
        if ({ready, ce, clk_div} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {ready, ce, clk_div});
        end
        reset = 1'b0;
        for (int i = 1; i <= LOCK; i++) begin
            step();
            checks++;
            if (ready !== (i == LOCK)) begin
                failures++;
                $display("FAIL lock_ready cycle=%0d got=%b exp=%b", i, ready, (i == LOCK));
            end
            checks++;
            if ({ce, clk_div} !== '0) begin
                failures++;
                $display("FAIL lock_outputs cycle=%0d got=%b exp=0", i, {ce, clk_div});
            end
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (ce !== {CH{k % 2 == 0}} || clk_div !== {CH{k % 2 == 0}}) begin
                failures++;
                $display("FAIL div2_pattern k=%0d got=%b/%b exp=%b", k, ce, clk_div, (k % 2 == 0));
            end
        end
    endtask

    task automatic test_odd_divisor();
        int n;
        load_div(0, 5);
        repeat (3) step();
        wait_ce(0, 10, n);
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL odd_sync got=timeout exp=ce");
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (clk_div[0] !== (i % 5 < 3) || ce[0] !== (i % 5 == 0)) begin
                failures++;
                $display("FAIL odd_pattern i=%0d got=%b/%b exp=%b/%b", i, ce[0], clk_div[0], (i % 5 == 0), (i % 5 < 3));
            end
            step();
        end
    endtask

    task automatic test_boundary_update();
        int n;
        load_div(0, 4);
        repeat (12) step();
        wait_ce(0, 10, n);
        step();
        div[0]      = 8'd3;
        div_load[0] = 1'b1;
        step();
        div_load[0] = 1'b0;
        wait_ce(0, 10, n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL update_current_period got=%0d exp=2 (4-cycle period)", n);
        end
        for (int p = 0; p < 2; p++) begin
            wait_ce(0, 10, n);
            checks++;
            if (n !== 3) begin
                failures++;
                $display("FAIL update_new_period p=%0d got=%0d exp=3", p, n);
            end
        end
        step();
        step();
        div[0]      = 8'd5;
        div_load[0] = 1'b1;
        step();
        div_load[0] = 1'b0;
        checks++;
        if (ce[0] !== 1'b1) begin
            failures++;
            $display("FAIL boundary_load_ce got=%b exp=1", ce[0]);
        end
        wait_ce(0, 10, n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL boundary_load_period got=%0d exp=5", n);
        end
    endtask

    task automatic test_stop_restart();
        int n;
        load_div(0, 6);
        repeat (12) step();
        wait_ce(0, 10, n);
        step();
        run[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (clk_div[0] !== (i == 1) || ce[0] !== 1'b0) begin
                failures++;
                $display("FAIL stop_tail i=%0d got=%b/%b exp=0/%b", i, ce[0], clk_div[0], (i == 1));
            end
        end
        run[0] = 1'b1;
        step();
        checks++;
        if (ce[0] !== 1'b1 || clk_div[0] !== 1'b1) begin
            failures++;
            $display("FAIL restart got=%b/%b exp=1/1", ce[0], clk_div[0]);
        end
    endtask

    task automatic test_edge_divisors();
        int hi;
        int ces;
        for (int v = 0; v < 2; v++) begin
            load_div(0, v);
            repeat (10) step();
            for (int i = 0; i < 8; i++) begin
                step();
                checks++;
                if (ce[0] !== 1'b1 || clk_div[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL div%0d_constant i=%0d got=%b/%b exp=1/1", v, i, ce[0], clk_div[0]);
                end
            end
        end
        load_div(0, 255);
        hi  = int'(clk_div[0]);
        ces = int'(ce[0]);
        for (int i = 1; i < 255; i++) begin
            step();
            hi  += int'(clk_div[0]);
            ces += int'(ce[0]);
        end
        checks++;
        if (hi !== 128 || ces !== 1) begin
            failures++;
            $display("FAIL div255_period got=hi%0d/ce%0d exp=hi128/ce1", hi, ces);
        end
        step();
        checks++;
        if (ce[0] !== 1'b1) begin
            failures++;
            $display("FAIL div255_next_ce got=%b exp=1", ce[0]);
        end
    endtask

    task automatic test_reset_mid();
        repeat (10) step();
        load_div(0, 7);
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++;
        if ({ready, ce, clk_div} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b exp=0", {ready, ce, clk_div});
        end
        reset = 1'b0;
        repeat (LOCK) step();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL relock_ready got=%b exp=1", ready);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (ce !== {CH{k % 2 == 0}} || clk_div !== {CH{k % 2 == 0}}) begin
                failures++;
                $display("FAIL relock_div_reset k=%0d got=%b/%b exp=%b", k, ce, clk_div, (k % 2 == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 799) == 0);
            for (int c = 0; c < CH; c++) begin
                run[c]      = ($urandom_range(0, 5) != 0);
                div_load[c] = ($urandom_range(0, 7) == 0);
                div[c]      = DW'($urandom_range(0, 12));
            end
            step();
            checks++;
            if ({ready, ce, clk_div} !== exp_vec()) begin
                failures++;
                $display("FAIL random_model cycle=%0d got=%b exp=%b", i, {ready, ce, clk_div}, exp_vec());
            end
        end
        reset    = 1'b0;
        div_load = '0;
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_act[c]  = 0;
            m_pos[c]  = 0;
            m_d[c]    = eff(DRESET);
            m_pend[c] = 0;
            m_pv[c]   = 0;
        end
        m_lock   = 0;
        m_ready  = 0;
        reset    = 1'b1;
        run      = '0;
        div      = '0;
        div_load = '0;
        repeat (3) step();

        test_reset();
        test_odd_divisor();
        test_boundary_update();
        test_stop_restart();
        test_edge_divisors();
        test_reset_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_div_gen
